// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and constants for the reaction timer game
//
// Provides the game state encoding, display/result limits, counter widths
// and the LFSR tap mask with its feedback helper.

package rt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        TIMING,
        DONE,
        FALSE_START
    } rt_state_t;

    // Largest value the 4-digit display can show.
    localparam int DISP_MAX = 9999;

    localparam int RESULT_W = 14;
    localparam int DELAY_W  = 13;
    localparam int LFSR_W   = 16;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR
//
// Ports:
//   clk      input   clock, state advances on every rising edge
//   reset_n  input   synchronous active-low reset, loads SEED
//   value    output  current 16-bit LFSR state
//
// SEED must be non-zero; with maximal-length taps the register then never
// reaches the all-zero lock-up state.

module lfsr16
    import rt_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= SEED;
        end else begin
            value <= {value[LFSR_W-2:0], lfsr_feedback(value)};
        end
    end

endmodule

// File: rtl/reaction_timer_fsm.sv
// rtl/reaction_timer_fsm.sv - reaction timer game controller and ms counter
//
// Ports:
//   clk_50MHz     input   system clock
//   reset_n       input   synchronous active-low reset
//   tick_1kHz     input   one-cycle pulse every millisecond
//   start_btn     input   start button, debounced, active-high
//   react_btn     input   react button, debounced, active-high
//   led_go        output  high while the reaction is being timed
//   result_ms     output  last reaction time in ms (held until next result)
//   result_valid  output  high while a finished result is held
//   false_start   output  high after react was pressed before GO
//   timeout       output  high when the held result saturated at MAX_MS
//   busy          output  high during the foreperiod and timing phases
//
// All outputs are registered and change on the edge that samples the
// causing press or tick.

module reaction_timer_fsm
    import rt_pkg::*;
#(
    parameter int                MIN_DELAY_MS = 1000,
    parameter int                RAND_BITS    = 11,
    parameter int                MAX_MS       = DISP_MAX,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk_50MHz,
    input  logic                reset_n,
    input  logic                tick_1kHz,
    input  logic                start_btn,
    input  logic                react_btn,
    output logic                led_go,
    output logic [RESULT_W-1:0] result_ms,
    output logic                result_valid,
    output logic                false_start,
    output logic                timeout,
    output logic                busy
);

    localparam logic [RESULT_W-1:0] MAX_CNT    = RESULT_W'(MAX_MS);
    localparam logic [RESULT_W-1:0] MAX_CNT_M1 = RESULT_W'(MAX_MS - 1);

    logic [LFSR_W-1:0]  lfsr_value;
    logic               lfsr_unused_bits;
    logic               start_prev;
    logic               react_prev;
    logic               start_press;
    logic               react_press;
    logic [DELAY_W-1:0] delay_load;
    logic [DELAY_W-1:0] delay_cnt;
    logic [RESULT_W-1:0] ms_cnt;
    rt_state_t          state;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk_50MHz),
        .reset_n (reset_n),
        .value   (lfsr_value)
    );

    // Only the low RAND_BITS bits feed the foreperiod.
    assign lfsr_unused_bits = ^lfsr_value[LFSR_W-1:RAND_BITS];

    // A held button yields one press: only the 0->1 transition counts.
    assign start_press = start_btn & ~start_prev;
    assign react_press = react_btn & ~react_prev;

    assign delay_load = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_value[RAND_BITS-1:0]);

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_prev   <= 1'b0;
            react_prev   <= 1'b0;
            delay_cnt    <= '0;
            ms_cnt       <= '0;
            led_go       <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            start_prev <= start_btn;
            react_prev <= react_btn;

            case (state)
                IDLE, DONE, FALSE_START: begin
                    // result_ms is deliberately kept so the display still
                    // shows the previous score during the next foreperiod.
                    if (start_press) begin
                        state        <= WAIT;
                        delay_cnt    <= delay_load;
                        result_valid <= 1'b0;
                        false_start  <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                WAIT: begin
                    // React beats a same-cycle tick: pressing early is a
                    // false start even on the last foreperiod millisecond.
                    if (react_press) begin
                        state       <= FALSE_START;
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                    end else if (tick_1kHz) begin
                        if (delay_cnt == DELAY_W'(1)) begin
                            state     <= TIMING;
                            delay_cnt <= '0;
                            ms_cnt    <= '0;
                            led_go    <= 1'b1;
                        end else begin
                            delay_cnt <= delay_cnt - 1'b1;
                        end
                    end
                end

                TIMING: begin
                    // The press captures the count as it stood before any
                    // tick arriving in the same cycle.
                    if (react_press) begin
                        state        <= DONE;
                        result_ms    <= ms_cnt;
                        result_valid <= 1'b1;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                    end else if (tick_1kHz) begin
                        if (ms_cnt >= MAX_CNT_M1) begin
                            state        <= DONE;
                            ms_cnt       <= MAX_CNT;
                            result_ms    <= MAX_CNT;
                            result_valid <= 1'b1;
                            timeout      <= 1'b1;
                            led_go       <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
